// File: rtl/frame_tx.sv
// frame_tx: Manchester framer serialising a 96-bit uid/zid/cnt/type frame, optional preamble via FRAME_TX_PREAMBLE_EN
module frame_tx #(
  parameter int DIV      = 16,
  parameter int GAP_BITS = 8,
  parameter int PRE_LEN  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] uid,
  input  logic [7:0]  zid,
  input  logic [7:0]  cnt,
  input  logic [7:0]  typ,
  output logic        bout,
  output logic        ben,
  output logic        busy,
  output logic        done
);
`ifdef FRAME_TX_PREAMBLE_EN
  typedef enum logic [1:0] {IDLE, PRE, SEND, GAP} state_t;
  localparam logic [7:0] PRE_M1 = 8'(PRE_LEN - 1);
  if (PRE_LEN < 2 || PRE_LEN > 64 || PRE_LEN % 2 != 0) begin : g_pre_chk
    $error("frame_tx: PRE_LEN must be even and within 2..64");
  end
`else
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
`endif
  localparam logic [15:0] DIV_M1 = 16'(DIV - 1);
  localparam logic [7:0]  GAP_M1 = 8'(GAP_BITS - 1);
  state_t      state, state_nx;
  logic [15:0] div_cnt;
  logic [7:0]  bit_cnt;
  logic [95:0] sr;
  logic        tick, last;
  function automatic logic [15:0] man(input logic [7:0] b);
    man = '0;
    for (int i = 0; i < 8; i++) man[2*i +: 2] = b[i] ? 2'b10 : 2'b01;
  endfunction
  assign tick = div_cnt == DIV_M1;
  // last bit period of the current phase
  always_comb begin
    last = 1'b0;
    if (state == SEND) last = bit_cnt == 8'd95;
    if (state == GAP) last = bit_cnt == GAP_M1;
`ifdef FRAME_TX_PREAMBLE_EN
    if (state == PRE) last = bit_cnt == PRE_M1;
`endif
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next-state logic: each phase ends on the strobe of its last bit period
  always_comb begin
    state_nx = state;
    case (state)
`ifdef FRAME_TX_PREAMBLE_EN
      IDLE: state_nx = start ? PRE : IDLE;
      PRE:  state_nx = (tick && last) ? SEND : PRE;
`else
      IDLE: state_nx = start ? SEND : IDLE;
`endif
      SEND: state_nx = (tick && last) ? GAP : SEND;
      GAP:  state_nx = (tick && last) ? IDLE : GAP;
      default: state_nx = IDLE;
    endcase
  end
  // bit-period divider, bit counter and frame shift register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      sr      <= '0;
    end else begin
      div_cnt <= (state == IDLE || tick) ? 16'd0 : div_cnt + 16'd1;
      bit_cnt <= (state == IDLE || (tick && last)) ? 8'd0 : tick ? bit_cnt + 8'd1 : bit_cnt;
      if (state == IDLE && start)
        sr <= {8'hF0, man(typ), man(cnt), man(zid), man(uid[15:8]), man(uid[7:0]), 8'h0F};
      else if (state == SEND && tick)
        sr <= {sr[94:0], 1'b0};
    end
  // outputs decoded from state, divider and counters
  always_comb begin
    bout = state == SEND && sr[95];
    ben  = state == SEND && tick;
`ifdef FRAME_TX_PREAMBLE_EN
    if (state == PRE) begin
      bout = ~bit_cnt[0];
      ben  = tick;
    end
`endif
    done = state == GAP && tick && last;
    busy = state != IDLE && !done;
  end
endmodule

// File: tb/tb_frame_tx.sv
// tb_frame_tx: table, random-loopback and corner-sequence checks of frame_tx against a timing model
module tb_frame_tx;
  localparam int D = 4, G = 2, D2 = 2, G2 = 1;
`ifdef FRAME_TX_PREAMBLE_EN
  localparam int P = 8;
`else
  localparam int P = 0;
`endif
  localparam int NB = P + 96;
  logic clk = 0, rst_n = 0, start = 0, start2 = 0;
  logic [15:0] uid = 0;
  logic [7:0] zid = 0, cnt = 0, typ = 0;
  logic bout, ben, busy, done, bout2, ben2, busy2, done2;
  int checks = 0, failures = 0;

  frame_tx #(.DIV(D), .GAP_BITS(G), .PRE_LEN(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .uid(uid), .zid(zid), .cnt(cnt), .typ(typ),
    .bout(bout), .ben(ben), .busy(busy), .done(done));
  frame_tx #(.DIV(D2), .GAP_BITS(G2), .PRE_LEN(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .uid(uid), .zid(zid), .cnt(cnt), .typ(typ),
    .bout(bout2), .ben(ben2), .busy(busy2), .done(done2));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] man(input logic [7:0] b);
    logic [15:0] m;
    m = '0;
    for (int i = 7; i >= 0; i--) m = {m[13:0], b[i] ? 2'b10 : 2'b01};
    return m;
  endfunction

  function automatic logic [95:0] frame_of(input logic [15:0] u, input logic [7:0] z, c, t);
    return {8'hF0, man(t), man(c), man(z), man(u[15:8]), man(u[7:0]), 8'h0F};
  endfunction

  // receive-side decoder: {valid, type, cnt, zid, uid}
  function automatic logic [40:0] decode(input logic [95:0] w);
    logic [39:0] f;
    logic ok;
    logic [1:0] pr;
    ok = w[95:88] == 8'hF0 && w[7:0] == 8'h0F;
    f = '0;
    for (int i = 0; i < 40; i++) begin
      pr = w[8 + 2*i +: 2];
      ok = ok && (pr == 2'b10 || pr == 2'b01);
      f[i] = pr == 2'b10;
    end
    return {ok, f};
  endfunction

  task automatic run_frame(input logic [15:0] u, input logic [7:0] z, c, t, input bit inject,
                           output logic [95:0] cap, output int ndone, output int dcyc);
    logic [95:0] f;
    int tt, nben, idx;
    logic be, bene;
    f = frame_of(u, z, c, t);
    tt = (NB + G) * D;
    nben = 0; cap = '0; ndone = 0; dcyc = -1;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    uid = u; zid = z; cnt = c; typ = t; start = 1;
    @(posedge clk);
    #1 start = 0;
    for (int k = 1; k <= tt; k++) begin
      @(negedge clk);
      idx = (k - 1) / D;
      bene = (k % D == 0) && idx < NB;
      be = idx < P ? (idx % 2 == 0) : idx < NB ? f[95 - (idx - P)] : 1'b0;
      chk($sformatf("cyc%0d", k), {bout, ben, busy, done}, {be, bene, k < tt, k == tt});
      if (ben) begin
        nben++;
        if (nben > P) cap = {cap[94:0], bout};
      end
      if (done) begin ndone++; dcyc = k; end
      if (inject && k == (P + 50) * D + 1) begin
        uid = ~u; zid = ~z; cnt = ~c; typ = ~t; start = 1;
      end else start = 0;
    end
    @(negedge clk);
    chk("post_idle", {ben, busy, done}, 0);
  endtask

  typedef struct {
    logic [15:0] u;
    logic [7:0]  z, c, t;
    logic [95:0] f;
  } vec_t;

  initial begin
    vec_t tbl[4];
    logic [95:0] cap;
    int nd, dc, nben, t0, t1, t2, cyc, nd2;
    logic [15:0] ru;
    logic [7:0] rz, rc, rt;
    tbl[0] = '{16'hA55A, 8'h3C, 8'h01, 8'h01, 96'hF0_5556_5556_5AA5_9966_6699_0F};
    tbl[1] = '{16'h0000, 8'h00, 8'h00, 8'h00, 96'hF0_5555_5555_5555_5555_5555_0F};
    tbl[2] = '{16'hFFFF, 8'hFF, 8'hFF, 8'hFF, 96'hF0_AAAA_AAAA_AAAA_AAAA_AAAA_0F};
    tbl[3] = '{16'h00FF, 8'hF0, 8'h0F, 8'h80, 96'hF0_9555_55AA_AA55_5555_AAAA_0F};
    repeat (3) @(negedge clk);
    chk("reset_outs", {bout, ben, busy, done, bout2, ben2, busy2, done2}, 0);
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      run_frame(tbl[i].u, tbl[i].z, tbl[i].c, tbl[i].t, i == 0, cap, nd, dc);
      chk($sformatf("tbl%0d_frame", i), cap, tbl[i].f);
      chk($sformatf("tbl%0d_ndone", i), nd, 1);
      chk($sformatf("tbl%0d_done_cyc", i), dc, P ? 424 : 392);
    end
    for (int i = 0; i < 20; i++) begin
      ru = 16'($urandom); rz = 8'($urandom); rc = 8'($urandom); rt = 8'($urandom);
      run_frame(ru, rz, rc, rt, 0, cap, nd, dc);
      chk($sformatf("loop%0d", i), decode(cap), {1'b1, rt, rc, rz, ru});
    end
    // reset mid-frame at data bit 40
    @(negedge clk);
    uid = 16'h1234; zid = 8'h56; cnt = 8'h78; typ = 8'h9A; start = 1;
    @(posedge clk);
    #1 start = 0;
    nben = 0;
    for (int k = 0; k < 4000 && nben < P + 40; k++) begin
      @(negedge clk);
      if (ben) nben++;
    end
    chk("bit40_reached", nben, P + 40);
    #2 rst_n = 0;
    #1 chk("rst_async", {bout, ben, busy, done}, 0);
    nd = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) nd++;
      chk("rst_hold", {bout, ben, busy}, 0);
    end
    chk("rst_no_done", nd, 0);
    rst_n = 1;
    run_frame(tbl[0].u, tbl[0].z, tbl[0].c, tbl[0].t, 0, cap, nd, dc);
    chk("after_rst_frame", cap, tbl[0].f);
    chk("after_rst_ndone", nd, 1);
    // back-to-back frames with start held high
    @(negedge clk);
    start2 = 1;
    nben = 0; cyc = 0; nd2 = 0; t0 = -1; t1 = -1; t2 = -1;
    while (cyc < 4 * (NB + G2 + 1) * D2 && nben <= 2 * NB) begin
      @(negedge clk);
      cyc++;
      if (done2) nd2++;
      if (ben2) begin
        if (nben == 0) t0 = cyc;
        if (nben == NB) t1 = cyc;
        if (nben == 2 * NB) t2 = cyc;
        nben++;
      end
    end
    start2 = 0;
    chk("b2b_strobes", nben > 2 * NB, 1);
    chk("b2b_gap1", t1 - t0, (NB + G2) * D2 + 1);
    chk("b2b_gap2", t2 - t1, (NB + G2) * D2 + 1);
    chk("b2b_done", nd2, 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
